// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the mux-select arbiter.
interface mux_rr_arbiter_if;
  logic [3:0] Req;
  logic       Done;
  logic [1:0] Sel;
  logic [3:0] Grant;
  logic       Valid;
  logic       Timeout;

  modport master (
    output Req,
    output Done,
    input  Sel,
    input  Grant,
    input  Valid,
    input  Timeout
  );

  modport slave (
    input  Req,
    input  Done,
    output Sel,
    output Grant,
    output Valid,
    output Timeout
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the 4:1 mux select; holds Sel for a whole grant and
// inserts a one-cycle dead gap between owners with a bounded hold time.
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input logic              Clk,
  input logic              Rst,
  mux_rr_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] grant_q, grant_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;

  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       at_limit;
  logic       release_now;

  // First requester after the last owner, scanning ptr+1 .. ptr+4.
  always_comb begin
    winner = ptr_q;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && bus.Req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign at_limit    = (cnt_q == 8'(HOLD_MAX - 1));
  assign release_now = bus.Done || !bus.Req[owner_q] || at_limit;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|bus.Req) begin
          state_d = StGrant;
          owner_d = winner;
          sel_d   = winner;
          grant_d = 4'b0001 << winner;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        cnt_d = cnt_q + 8'd1;
        if (release_now) begin
          state_d   = StIdle;
          grant_d   = '0;
          valid_d   = 1'b0;
          ptr_d     = owner_q;
          // Flag only a pure hold-limit release, not a voluntary one.
          timeout_d = !bus.Done && bus.Req[owner_q];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= StIdle;
      ptr_q     <= 2'b11;
      cnt_q     <= '0;
      owner_q   <= '0;
      sel_q     <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.Sel     = sel_q;
  assign bus.Grant   = grant_q;
  assign bus.Valid   = valid_q;
  assign bus.Timeout = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: two instances (hold 4 and hold 1) driven
// with shared stimulus and checked against a behavioural model each cycle.
module tb_mux_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_rr_arbiter_if if4();
  mux_rr_arbiter_if if1();

  mux_rr_arbiter #(.HOLD_MAX(4)) dut4 (
    .Clk (clk),
    .Rst (rst),
    .bus (if4)
  );

  mux_rr_arbiter #(.HOLD_MAX(1)) dut1 (
    .Clk (clk),
    .Rst (rst),
    .bus (if1)
  );

  typedef struct {
    bit busy;
    int owner;
    int last;
    int held;
    int sel;
    bit tmo;
  } mstate_t;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       tmo;
  } exp_t;

  exp_t    q4[$];
  exp_t    q1[$];
  mstate_t m4, m1;
  int      n_total = 0;
  int      n_pass  = 0;

  // Model: "held" is the number of cycles the current owner has been granted.
  function automatic mstate_t step(mstate_t s, bit [3:0] req, bit done, bit r, int hold);
    mstate_t n;
    bit      rel;
    int      c;
    n = s;
    if (r) begin
      n.busy = 0; n.owner = 0; n.last = 3; n.held = 0; n.sel = 0; n.tmo = 0;
      return n;
    end
    n.tmo = 0;
    if (!s.busy) begin
      for (int k = 1; k <= 4; k++) begin
        c = (s.last + k) % 4;
        if (req[c]) begin
          n.busy = 1; n.owner = c; n.sel = c; n.held = 1;
          break;
        end
      end
    end else begin
      rel = done || !req[s.owner] || (s.held == hold);
      if (rel) begin
        n.busy = 0;
        n.last = s.owner;
        n.tmo  = !done && req[s.owner];
      end else begin
        n.held = s.held + 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t expect_of(mstate_t s);
    exp_t e;
    e.sel   = 2'(s.sel);
    e.grant = s.busy ? 4'(1 << s.owner) : 4'b0000;
    e.valid = s.busy;
    e.tmo   = s.tmo;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input logic [3:0] req, input logic done, input logic r);
    rst      = r;
    if4.Req  = req;
    if4.Done = done;
    if1.Req  = req;
    if1.Done = done;
    @(posedge clk);
    m4 = step(m4, req, done, r, 4);
    m1 = step(m1, req, done, r, 1);
    q4.push_back(expect_of(m4));
    q1.push_back(expect_of(m1));
    @(negedge clk);
  endtask

  task automatic mon(input string tag, input exp_t e, input logic [1:0] sel,
                     input logic [3:0] grant, input logic valid, input logic tmo,
                     input int hold, inout int run, inout logic pv, inout logic [3:0] pg);
    check({tag, "_sel"},     32'(sel),   32'(e.sel));
    check({tag, "_grant"},   32'(grant), 32'(e.grant));
    check({tag, "_valid"},   32'(valid), 32'(e.valid));
    check({tag, "_timeout"}, 32'(tmo),   32'(e.tmo));
    check({tag, "_sel_vs_grant"}, 32'(grant), valid ? 32'(4'b0001 << sel) : 32'd0);
    run = valid ? run + 1 : 0;
    check({tag, "_hold_bound"}, 32'(run > hold), 32'd0);
    if (pv && valid) check({tag, "_no_b2b"}, 32'(grant), 32'(pg));
    pv = valid;
    pg = grant;
  endtask

  int         run4 = 0, run1 = 0;
  logic       pv4 = 1'b0, pv1 = 1'b0;
  logic [3:0] pg4 = '0, pg1 = '0;
  exp_t       e4, e1;

  always @(negedge clk) begin
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      mon("h4", e4, if4.Sel, if4.Grant, if4.Valid, if4.Timeout, 4, run4, pv4, pg4);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      mon("h1", e1, if1.Sel, if1.Grant, if1.Valid, if1.Timeout, 1, run1, pv1, pg1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [3:0] rreq;
  logic       rdone;
  logic       rrst;

  initial begin
    m4 = '{busy: 0, owner: 0, last: 3, held: 0, sel: 0, tmo: 0};
    m1 = m4;
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'h0, 1'b0, 1'b1);
    // All channels requesting: rotating 4-cycle grants with timeouts.
    repeat (26) cyc(4'hf, 1'b0, 1'b0);
    // Single requester with early Done, then regrant.
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0);
    repeat (3) cyc(4'b0100, 1'b0, 1'b0);
    // Owner 1 drops its request while channel 3 waits.
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'b1010, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    repeat (3) cyc(4'b1000, 1'b0, 1'b0);
    // Reset in the middle of channel 2's grant.
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b1);
    repeat (4) cyc(4'b1100, 1'b0, 1'b0);
    // Two requesters: alternating grants.
    cyc(4'h0, 1'b0, 1'b1);
    repeat (10) cyc(4'b0011, 1'b0, 1'b0);
    // Random traffic with sticky requests and occasional reset.
    rreq = 4'h0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) rreq = 4'($urandom_range(0, 15));
      rdone = ($urandom_range(0, 5) == 0);
      rrst  = ($urandom_range(0, 499) == 0);
      cyc(rreq, rdone, rrst);
    end
    @(negedge clk);
    #1;
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
